up_mem_loader: RTL and testbench

- Byte-stream host loader that sits directly upstream of the up memory and drives its address, write-data and write-enable inputs.
- Lets a host (UART/bridge stream) write program/data images into memory and read them back before or between CPU runs.
- Decodes simple framed commands: `W addr len data...` and `R addr len`.
- Read data comes straight from the memory's combinational read port.

---
 rtl/up_mem_loader.sv | 215 +++++++++++++++++++++
 tb/tb_up_mem_loader.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/up_mem_loader.sv
// up_mem_loader: framed byte-stream host loader sitting in front of the up memory.
// Frames: CMD_WR addr len data... [csum] writes memory; CMD_RD addr len reads it back.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   rx_data/valid/ready  inbound command/data stream
//   tx_data/valid/ready  read-back stream
//   mem_addr/wdata/we    memory write port and shared address
//   mem_rdata/rdy        memory combinational read data and its valid
//   busy            frame in progress (CPU must be held)
//   err             one-cycle pulse on a bad command byte or bad checksum
// Build option: define UP_MEM_LOADER_CHECKSUM_EN to require a trailing
// checksum byte (sum mod 256 of addr, len and data) on write frames.
module up_mem_loader #(
    parameter int unsigned   AW     = 8,
    parameter int unsigned   DW     = 8,
    parameter logic [DW-1:0] CMD_WR = 8'h57,
    parameter logic [DW-1:0] CMD_RD = 8'h52
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] rx_data,
    input  logic          rx_valid,
    output logic          rx_ready,
    output logic [DW-1:0] tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_rdy,
    output logic          busy,
    output logic          err
);

    // Count needs one extra bit so a length byte of 0 can mean 2^AW.
    localparam int unsigned CW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LEN,
        S_WDATA,
        S_RDATA
`ifdef UP_MEM_LOADER_CHECKSUM_EN
        ,
        S_CSUM
`endif
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_op_wr;
    logic [AW-1:0]   r_addr;
    logic [CW-1:0]   r_count;
    logic            r_err;

    logic            w_rx_acc;
    logic            w_tx_acc;
    logic            w_last;
    logic            w_is_cmd;
    logic            w_bad_cmd;
    logic            w_bad_sum;

`ifdef UP_MEM_LOADER_CHECKSUM_EN
    logic [DW-1:0]   r_sum;
`endif

    assign w_rx_acc  = rx_valid & rx_ready;
    assign w_tx_acc  = tx_valid & tx_ready;
    assign w_last    = (r_count == CW'(1));
    assign w_is_cmd  = (rx_data == CMD_WR) || (rx_data == CMD_RD);
    assign w_bad_cmd = (r_state == S_IDLE) && w_rx_acc && !w_is_cmd;

`ifdef UP_MEM_LOADER_CHECKSUM_EN
    assign w_bad_sum = (r_state == S_CSUM) && w_rx_acc && (rx_data != r_sum);
`else
    assign w_bad_sum = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_rx_acc && w_is_cmd) begin
                    w_next = S_ADDR;
                end
            end
            S_ADDR: begin
                if (w_rx_acc) begin
                    w_next = S_LEN;
                end
            end
            S_LEN: begin
                if (w_rx_acc) begin
                    w_next = r_op_wr ? S_WDATA : S_RDATA;
                end
            end
            S_WDATA: begin
                if (w_rx_acc && w_last) begin
`ifdef UP_MEM_LOADER_CHECKSUM_EN
                    w_next = S_CSUM;
`else
                    w_next = S_IDLE;
`endif
                end
            end
            S_RDATA: begin
                if (w_tx_acc && w_last) begin
                    w_next = S_IDLE;
                end
            end
`ifdef UP_MEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (w_rx_acc) begin
                    w_next = S_IDLE;
                end
            end
`endif
            default: w_next = S_IDLE;
        endcase
    end

    // Output logic: only one stream is open per state.
    always_comb begin
        rx_ready = 1'b1;
        tx_valid = 1'b0;
        mem_we   = 1'b0;
        busy     = (r_state != S_IDLE);
        case (r_state)
            S_WDATA: mem_we = rx_valid;
            S_RDATA: begin
                rx_ready = 1'b0;
                tx_valid = mem_rdy;
            end
            default: ;
        endcase
    end

    // Memory writes land on the same edge the data byte is accepted, so
    // the write port is a direct pass-through of the inbound byte.
    assign mem_addr  = r_addr;
    assign mem_wdata = rx_data;
    assign tx_data   = mem_rdata;
    assign err       = r_err;

    // Frame datapath: opcode, address pointer, remaining count, error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_wr <= 1'b0;
            r_addr  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_bad_cmd | w_bad_sum;
            case (r_state)
                S_IDLE: begin
                    if (w_rx_acc) begin
                        r_op_wr <= (rx_data == CMD_WR);
                    end
                end
                S_ADDR: begin
                    if (w_rx_acc) begin
                        r_addr <= rx_data[AW-1:0];
                    end
                end
                S_LEN: begin
                    if (w_rx_acc) begin
                        r_count <= {(rx_data[AW-1:0] == '0), rx_data[AW-1:0]};
                    end
                end
                S_WDATA: begin
                    if (w_rx_acc) begin
                        r_addr  <= r_addr + AW'(1);
                        r_count <= r_count - CW'(1);
                    end
                end
                S_RDATA: begin
                    if (w_tx_acc) begin
                        r_addr  <= r_addr + AW'(1);
                        r_count <= r_count - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef UP_MEM_LOADER_CHECKSUM_EN
    // Running sum of addr, len and data bytes for the trailing check byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum <= '0;
        end else if (w_rx_acc) begin
            case (r_state)
                S_ADDR:  r_sum <= rx_data;
                S_LEN:   r_sum <= r_sum + rx_data;
                S_WDATA: r_sum <= r_sum + rx_data;
                default: ;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_up_mem_loader.sv
// tb_up_mem_loader: directed frames against a frame-level reference model.
// A per-cycle monitor checks writes, read-back bytes and error pulses.
module tb_up_mem_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b1;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic [7:0] mem_rdata;
    logic       mem_rdy = 1'b1;
    logic       busy;
    logic       err;

    up_mem_loader dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .mem_rdy   (mem_rdy),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    // The memory the loader drives.
    logic [7:0] bmem [0:255] = '{default: 8'h00};
    always @(posedge clk) if (mem_we) bmem[mem_addr] <= mem_wdata;
    assign mem_rdata = bmem[mem_addr];

    // Reference model: memory image plus queues of expected effects.
    logic [7:0]  ref_mem [0:255] = '{default: 8'h00};
    logic [15:0] exp_w[$];
    logic [7:0]  exp_tx[$];
    logic [7:0]  dq[$];
    int          err_exp = 0;
    int          errors = 0;
    int          checks = 0;
    bit          csum_bad = 1'b0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endfunction

    // Per-cycle monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_we) begin
                chk("we_pending", 32'(exp_w.size() > 0), 1);
                if (exp_w.size() > 0)
                    chk("we_addr_data", {mem_addr, mem_wdata}, exp_w.pop_front());
            end
            if (tx_valid) begin
                chk("tx_pending", 32'(exp_tx.size() > 0), 1);
                if (exp_tx.size() > 0) begin
                    chk("tx_data", tx_data, exp_tx[0]);
                    if (tx_ready) void'(exp_tx.pop_front());
                end
            end
            if (err) begin
                chk("err_expected", 32'(err_exp > 0), 1);
                if (err_exp > 0) err_exp--;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int  n;
        bit  acc;
        n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        forever begin
            @(negedge clk);
            acc = rx_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            n++;
            if (n > 20) begin
                chk("rx_ready_timeout", rx_ready, 1);
                break;
            end
        end
        rx_valid = 1'b0;
    endtask

    task automatic wr_frame(input logic [7:0] a, input logic [7:0] l);
        int         n;
        logic [7:0] ad;
        logic [7:0] s;
        n = (l == 8'h00) ? 256 : int'(l);
        s = a + l;
        for (int i = 0; i < n; i++) begin
            ad = a + 8'(i);
            ref_mem[ad] = dq[i];
            exp_w.push_back({ad, dq[i]});
            s = s + dq[i];
        end
        send_byte(8'h57);
        send_byte(a);
        send_byte(l);
        for (int i = 0; i < n; i++) begin
            if (i == n - 1) chk("busy_before_last", busy, 1);
            send_byte(dq[i]);
        end
`ifdef UP_MEM_LOADER_CHECKSUM_EN
        chk("busy_in_csum", busy, 1);
        if (csum_bad) begin
            err_exp++;
            s = s + 8'h01;
        end
        send_byte(s);
`else
        s = s + 8'h00;
`endif
        chk("busy_after_wr", busy, 0);
        dq.delete();
    endtask

    task automatic rd_frame(input logic [7:0] a, input logic [7:0] l, input int hold);
        int n;
        int cnt;
        n = (l == 8'h00) ? 256 : int'(l);
        for (int i = 0; i < n; i++) exp_tx.push_back(ref_mem[a + 8'(i)]);
        if (hold > 0) tx_ready = 1'b0;
        send_byte(8'h52);
        send_byte(a);
        send_byte(l);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_tx_valid", tx_valid, 1);
            chk("hold_tx_data", tx_data, ref_mem[a]);
            chk("hold_rx_ready", rx_ready, 0);
        end
        if (hold > 0) begin
            @(posedge clk);
            #1;
            tx_ready = 1'b1;
        end
        cnt = 0;
        while (exp_tx.size() > 0 && cnt < 600) begin
            chk("rd_rx_ready", rx_ready, 0);
            @(posedge clk);
            #1;
            cnt++;
        end
        chk("rd_drained", exp_tx.size(), 0);
        chk("busy_after_rd", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rx_ready", rx_ready, 1);
        @(posedge clk);
        #1;

        // Basic write then read back.
        dq = '{8'hAA, 8'hBB, 8'hCC};
        wr_frame(8'h10, 8'h03);
        chk("lit_mem10", bmem[8'h10], 8'hAA);
        chk("lit_mem12", bmem[8'h12], 8'hCC);
        rd_frame(8'h10, 8'h03, 0);

        // Address wrap across the top of memory.
        dq = '{8'h01, 8'h02, 8'h03};
        wr_frame(8'hFE, 8'h03);
        chk("lit_memFF", bmem[8'hFF], 8'h02);
        chk("lit_mem00", bmem[8'h00], 8'h03);
        rd_frame(8'hFE, 8'h03, 0);

        // Read with output backpressure.
        rd_frame(8'h00, 8'h02, 5);

        // Length 0 means 256 bytes.
        for (int i = 0; i < 256; i++) dq.push_back(8'(i));
        wr_frame(8'h00, 8'h00);
        chk("lit_mem80", bmem[8'h80], 8'h80);
        chk("lit_memFF_len0", bmem[8'hFF], 8'hFF);

        // Bad command byte.
        err_exp++;
        send_byte(8'h33);
        chk("badcmd_err", err, 1);
        chk("badcmd_busy", busy, 0);
        @(posedge clk);
        #1;
        chk("badcmd_err_1cyc", err, 0);

        // Reset in the middle of a write frame.
        exp_w.push_back({8'h20, 8'h11});
        ref_mem[8'h20] = 8'h11;
        send_byte(8'h57);
        send_byte(8'h20);
        send_byte(8'h02);
        send_byte(8'h11);
        rx_data  = 8'h22;
        rx_valid = 1'b1;
        rst      = 1'b1;
        #1;
        chk("midrst_we", mem_we, 0);
        chk("midrst_busy", busy, 0);
        rx_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("lit_mem20", bmem[8'h20], 8'h11);
        chk("lit_mem21", bmem[8'h21], 8'h21);
        rd_frame(8'h20, 8'h02, 0);

`ifdef UP_MEM_LOADER_CHECKSUM_EN
        csum_bad = 1'b0;
        dq = '{8'h05};
        wr_frame(8'h00, 8'h01);
        @(posedge clk);
        #1;
        chk("csum_ok_err", err, 0);
        csum_bad = 1'b1;
        dq = '{8'h05};
        wr_frame(8'h00, 8'h01);
        chk("csum_bad_err", err, 1);
        chk("lit_csum_mem0", bmem[8'h00], 8'h05);
        csum_bad = 1'b0;
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("writes_drained", exp_w.size(), 0);
        chk("errs_seen", err_exp, 0);
        for (int i = 0; i < 256; i++) chk("mem_image", bmem[i], ref_mem[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
